// File: rtl/comparador_pkg.sv
// rtl/comparador_pkg.sv - op_sel codes, FSM state constants and relation select function for comparador_seq
package comparador_pkg;

    // op_sel encoding for the relation driven on RESULTADO
    localparam logic [2:0] OP_EQ = 3'd0;
    localparam logic [2:0] OP_NE = 3'd1;
    localparam logic [2:0] OP_GT = 3'd2;
    localparam logic [2:0] OP_GE = 3'd3;
    localparam logic [2:0] OP_LT = 3'd4;
    localparam logic [2:0] OP_LE = 3'd5;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Maps the final relation flags and the latched op to RESULTADO; codes 6/7 give 0
    function automatic logic resultado_f(input logic eq, input logic gt, input logic lt,
                                         input logic [2:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_EQ:   r = eq;
            OP_NE:   r = ~eq;
            OP_GT:   r = gt;
            OP_GE:   r = gt | eq;
            OP_LT:   r = lt;
            OP_LE:   r = lt | eq;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/comparador_digito.sv
// rtl/comparador_digito.sv - combinational unsigned compare of one DIGIT-bit slice
module comparador_digito #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             dgt,
    output logic             dlt
);

    assign dgt = (a > b);
    assign dlt = (a < b);

endmodule

// File: rtl/comparador_seq.sv
// rtl/comparador_seq.sv - multi-cycle MSB-first magnitude comparator (optional COMPARADOR_SEQ_EARLY_EXIT_EN)
module comparador_seq
    import comparador_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    input  logic [2:0]       op_sel,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             RESULTADO
);

    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [IDX_W-1:0] idx;
    logic             gt_q;
    logic             lt_q;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic             dgt;
    logic             dlt;
    logic             decided;
    logic             gt_n;
    logic             lt_n;
    logic             last_dig;
    logic             finish;
    logic             in_done;
    logic             eq_c;

    // Flipping the sign bit maps two's-complement order onto unsigned order
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    assign a_in = {A[WIDTH-1] ^ signed_mode, A[WIDTH-2:0]};
    assign b_in = {B[WIDTH-1] ^ signed_mode, B[WIDTH-2:0]};

    assign a_dig = a_q[32'(idx) * DIGIT +: DIGIT];
    assign b_dig = b_q[32'(idx) * DIGIT +: DIGIT];

    comparador_digito #(
        .DIGIT(DIGIT)
    ) u_digito (
        .a   (a_dig),
        .b   (b_dig),
        .dgt (dgt),
        .dlt (dlt)
    );

    // The first differing digit from the MSB decides; later digits cannot override it
    assign decided  = gt_q | lt_q;
    assign gt_n     = gt_q | (~decided & dgt);
    assign lt_n     = lt_q | (~decided & dlt);
    assign last_dig = (idx == '0);

`ifdef COMPARADOR_SEQ_EARLY_EXIT_EN
    assign finish = last_dig | (~decided & (dgt | dlt));
`else
    assign finish = last_dig;
`endif

    // Control FSM plus operand/decision registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            idx   <= '0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        op_q  <= op_sel;
                        idx   <= IDX_TOP;
                        gt_q  <= 1'b0;
                        lt_q  <= 1'b0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    gt_q <= gt_n;
                    lt_q <= lt_n;
                    if (!last_dig) begin
                        idx <= idx - 1'b1;
                    end
                    if (finish) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (done_ready) begin
                        gt_q  <= 1'b0;
                        lt_q  <= 1'b0;
                        op_q  <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Results are only visible in DONE, and are exactly one-hot there
    assign in_done     = (state == ST_DONE);
    assign start_ready = (state == ST_IDLE);
    assign done_valid  = in_done;
    assign eq_c        = ~gt_q & ~lt_q;
    assign eq          = in_done & eq_c;
    assign gt          = in_done & gt_q;
    assign lt          = in_done & lt_q;
    assign RESULTADO   = in_done & resultado_f(eq_c, gt_q, lt_q, op_q);

endmodule

// File: tb/tb_comparador_seq.sv
// tb/tb_comparador_seq.sv - scoreboard bench for comparador_seq (latency follows COMPARADOR_SEQ_EARLY_EXIT_EN)
module tb_comparador_seq;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        signed_mode;
    logic [2:0]  op_sel;
    logic        done_valid;
    logic        done_ready;
    logic        eq;
    logic        gt;
    logic        lt;
    logic        RESULTADO;

    comparador_seq #(
        .WIDTH(16),
        .DIGIT(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .A           (A),
        .B           (B),
        .signed_mode (signed_mode),
        .op_sel      (op_sel),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .eq          (eq),
        .gt          (gt),
        .lt          (lt),
        .RESULTADO   (RESULTADO)
    );

    typedef struct {
        logic eq;
        logic gt;
        logic lt;
        logic res;
        int   k;
        int   lat;
        int   id;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   chk_cnt   = 0;
    int   pass_cnt  = 0;
    logic prev_dv   = 1'b0;
    logic [3:0] held = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per rising done_valid, then checks the result stays stable
    always @(negedge clk) begin
        if (rst_n) begin
            if (done_valid) begin
                if (!prev_dv) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", {31'd0, done_valid}, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        $display("op %0d: eq=%0b gt=%0b lt=%0b res=%0b lat=%0d", e.id, eq, gt, lt, RESULTADO, cyc - e.k);
                        chk($sformatf("op%0d_eq", e.id),  {31'd0, eq},        {31'd0, e.eq});
                        chk($sformatf("op%0d_gt", e.id),  {31'd0, gt},        {31'd0, e.gt});
                        chk($sformatf("op%0d_lt", e.id),  {31'd0, lt},        {31'd0, e.lt});
                        chk($sformatf("op%0d_res", e.id), {31'd0, RESULTADO}, {31'd0, e.res});
                        chk($sformatf("op%0d_latency", e.id), 32'(cyc - e.k), 32'(e.lat));
                        chk($sformatf("op%0d_onehot", e.id), 32'(int'(eq) + int'(gt) + int'(lt)), 32'd1);
                    end
                    held = {eq, gt, lt, RESULTADO};
                end else begin
                    chk("held_result_stable", {28'd0, eq, gt, lt, RESULTADO}, {28'd0, held});
                end
            end
            prev_dv = done_valid;
        end else begin
            prev_dv = 1'b0;
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sm,
                         input logic [2:0] op, input logic e_eq, input logic e_gt,
                         input logic e_lt, input logic e_res, input int lat_full,
                         input int lat_early, input int id, input bit push);
        int t;
        exp_t e;
        @(negedge clk);
        A = a;
        B = b;
        signed_mode = sm;
        op_sel = op;
        start_valid = 1'b1;
        t = 0;
        while (!start_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!start_ready) chk("accept_timeout", {31'd0, start_ready}, 32'd1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        if (push) begin
            e.eq = e_eq; e.gt = e_gt; e.lt = e_lt; e.res = e_res;
            e.k = cyc; e.id = id;
`ifdef COMPARADOR_SEQ_EARLY_EXIT_EN
            e.lat = lat_early;
`else
            e.lat = lat_full;
`endif
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        @(negedge clk);
        while (!(done_valid && done_ready) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!(done_valid && done_ready)) chk("done_timeout", {31'd0, done_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic sm,
                       input logic [2:0] op, input logic e_eq, input logic e_gt,
                       input logic e_lt, input logic e_res, input int lat_full,
                       input int lat_early, input int id);
        issue(a, b, sm, op, e_eq, e_gt, e_lt, e_res, lat_full, lat_early, id, 1'b1);
        wait_done();
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        start_valid = 1'b0;
        A = '0;
        B = '0;
        signed_mode = 1'b0;
        op_sel = '0;
        done_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {27'd0, done_valid, eq, gt, lt, RESULTADO}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_start_ready", {31'd0, start_ready}, 32'd1);
        chk("reset_done_valid", {31'd0, done_valid}, 32'd0);

        //   A        B        sm    op    eq gt lt res  full early id
        run(16'h1234, 16'h1234, 1'b0, 3'd3, 1, 0, 0, 1, 4, 4, 1);
        run(16'h8000, 16'h7FFF, 1'b0, 3'd2, 0, 1, 0, 1, 4, 1, 2);
        run(16'h8000, 16'h7FFF, 1'b1, 3'd2, 0, 0, 1, 0, 4, 1, 3);
        run(16'h0001, 16'h0002, 1'b0, 3'd5, 0, 0, 1, 1, 4, 4, 4);
        run(16'hFFFF, 16'hFFFF, 1'b1, 3'd6, 1, 0, 0, 0, 4, 4, 5);
        run(16'h0500, 16'h0400, 1'b0, 3'd1, 0, 1, 0, 1, 4, 2, 6);
        run(16'h00F0, 16'h0100, 1'b0, 3'd4, 0, 0, 1, 1, 4, 2, 7);
        run(16'hFFFF, 16'h0001, 1'b1, 3'd3, 0, 0, 1, 0, 4, 1, 8);
        run(16'h1235, 16'h1234, 1'b0, 3'd0, 0, 1, 0, 0, 4, 4, 9);
        run(16'h0000, 16'h1000, 1'b0, 3'd7, 0, 0, 1, 0, 4, 1, 10);
        run(16'h0003, 16'h0003, 1'b1, 3'd1, 1, 0, 0, 0, 4, 4, 11);

        // Backpressure: result held while done_ready is low and start_valid is asserted
        done_ready = 1'b0;
        issue(16'h00A0, 16'h0050, 1'b0, 3'd2, 0, 1, 0, 1, 4, 3, 12, 1'b1);
        t = 0;
        while (!done_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("bp_done_seen", {31'd0, done_valid}, 32'd1);
        A = 16'h0000;
        B = 16'hFFFF;
        op_sel = 3'd0;
        start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_start_ready_low", {31'd0, start_ready}, 32'd0);
            chk("bp_done_valid_held", {31'd0, done_valid}, 32'd1);
        end
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        chk("bp_release_done_valid", {31'd0, done_valid}, 32'd0);
        chk("bp_release_start_ready", {31'd0, start_ready}, 32'd1);
        @(negedge clk);
        chk("bp_no_extra_accept", {31'd0, start_ready}, 32'd1);

        // Reset mid-BUSY: no result may appear for the aborted operation
        issue(16'h1111, 16'h2222, 1'b0, 3'd4, 0, 0, 1, 1, 4, 1, 13, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midbusy_reset_outputs", {27'd0, done_valid, eq, gt, lt, RESULTADO}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midbusy_start_ready", {31'd0, start_ready}, 32'd1);
        chk("midbusy_done_valid", {31'd0, done_valid}, 32'd0);

        run(16'h4321, 16'h4321, 1'b0, 3'd0, 1, 0, 0, 1, 4, 4, 14);
        run(16'h7000, 16'h9000, 1'b1, 3'd2, 0, 1, 0, 1, 4, 1, 15);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
